// File: rtl/pick_pkg.sv
// Shared definitions for the pick direction controller and the movement stage.
// Holds the dir encodings, the default keycodes and timing, and the controller state type.
package pick_pkg;

  localparam logic [2:0] DIR_STOP = 3'b000;
  localparam logic [2:0] DIR_UP1  = 3'b001;
  localparam logic [2:0] DIR_DN1  = 3'b010;
  localparam logic [2:0] DIR_DN2  = 3'b011;
  localparam logic [2:0] DIR_UP2  = 3'b100;

  localparam logic [7:0] KEY_UP_DEF         = 8'h1A;
  localparam logic [7:0] KEY_DOWN_DEF       = 8'h16;
  localparam int         HOLD_FRAMES_DEF    = 30;
  localparam int         RELEASE_FRAMES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UP_SLOW,
    ST_UP_FAST,
    ST_DN_SLOW,
    ST_DN_FAST
  } pick_dir_state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_UP,
    REQ_DN
  } pick_req_t;

  function automatic logic [2:0] dir_of(input pick_dir_state_t st);
    case (st)
      ST_UP_SLOW: dir_of = DIR_UP1;
      ST_UP_FAST: dir_of = DIR_UP2;
      ST_DN_SLOW: dir_of = DIR_DN1;
      ST_DN_FAST: dir_of = DIR_DN2;
      default:    dir_of = DIR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/pick_dir_ctrl.sv
// Per-frame keyboard-to-dir controller: slow/fast ramp on hold, filtered release.
// Latency 1 frame (dir registered from next state); no backpressure, keys sampled every frame.
module pick_dir_ctrl
  import pick_pkg::*;
#(
  parameter logic [7:0] KEY_UP         = KEY_UP_DEF,
  parameter logic [7:0] KEY_DOWN       = KEY_DOWN_DEF,
  parameter int         HOLD_FRAMES    = HOLD_FRAMES_DEF,
  parameter int         RELEASE_FRAMES = RELEASE_FRAMES_DEF
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic [2:0] dir,
  output logic       fast
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
  localparam logic [3:0] REL_LAST  = 4'(RELEASE_FRAMES - 1);

  pick_dir_state_t r_state;
  pick_dir_state_t w_state_nxt;
  logic [7:0]      r_hold_cnt;
  logic [7:0]      w_hold_nxt;
  logic [3:0]      r_rel_cnt;
  logic [3:0]      w_rel_nxt;
  logic [2:0]      r_dir;
  logic            r_fast;

  logic            w_up_req;
  logic            w_dn_req;
  pick_req_t       w_req;
  pick_req_t       w_cur_dir;
  logic            w_slow;

  assign w_up_req = (keycode0 == KEY_UP)   | (keycode1 == KEY_UP);
  assign w_dn_req = (keycode0 == KEY_DOWN) | (keycode1 == KEY_DOWN);

  // Both keys at once is a conflict and reads as no request.
  always_comb begin
    w_req = REQ_NONE;
    if (w_up_req && !w_dn_req) w_req = REQ_UP;
    else if (w_dn_req && !w_up_req) w_req = REQ_DN;
  end

  assign w_cur_dir = ((r_state == ST_UP_SLOW) || (r_state == ST_UP_FAST)) ? REQ_UP : REQ_DN;
  assign w_slow    = (r_state == ST_UP_SLOW) || (r_state == ST_DN_SLOW);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_rel_nxt   = r_rel_cnt;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_hold_nxt  = '0;
      w_rel_nxt   = '0;
    end else if (r_state == ST_IDLE) begin
      w_hold_nxt = '0;
      w_rel_nxt  = '0;
      if (w_req == REQ_UP)      w_state_nxt = ST_UP_SLOW;
      else if (w_req == REQ_DN) w_state_nxt = ST_DN_SLOW;
    end else if (w_req == REQ_NONE) begin
      // Hold state through short dropouts; hold_cnt is left alone so the ramp resumes.
      if (r_rel_cnt == REL_LAST) begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
        w_rel_nxt   = '0;
      end else if (r_rel_cnt != 4'hF) begin
        w_rel_nxt = r_rel_cnt + 4'd1;
      end
    end else if (w_req == w_cur_dir) begin
      w_rel_nxt = '0;
      if (w_slow) begin
        if (r_hold_cnt != 8'hFF) w_hold_nxt = r_hold_cnt + 8'd1;
        if (r_hold_cnt == HOLD_LAST)
          w_state_nxt = (w_req == REQ_UP) ? ST_UP_FAST : ST_DN_FAST;
      end
    end else begin
      w_state_nxt = (w_req == REQ_UP) ? ST_UP_SLOW : ST_DN_SLOW;
      w_hold_nxt  = '0;
      w_rel_nxt   = '0;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_rel_cnt  <= '0;
      r_dir      <= DIR_STOP;
      r_fast     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rel_cnt  <= w_rel_nxt;
      r_dir      <= dir_of(w_state_nxt);
      r_fast     <= (w_state_nxt == ST_UP_FAST) || (w_state_nxt == ST_DN_FAST);
    end
  end

  assign dir  = r_dir;
  assign fast = r_fast;

endmodule
